// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_W     = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM: write-enable plus registered read, contents not reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ready handshake with WAIT_STATES wait cycles and a store log.
// Optional macro DMEM_MISALIGN_TRAP_EN turns DataAdr[1:0]!=0 into a fault.
//
// state | meaning
// IDLE  | waiting for MemReq; request captured on the accepting edge
// WAIT  | wait-state countdown, inputs ignored
// RESP  | MemReady pulse; store/read-data/log committed on the closing edge
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  parameter  int WAIT_STATES = 2,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic [31:0] LastStAdr,
  output logic [31:0] LastStData,
  output logic [15:0] StCount
);

  localparam int OFS = $clog2(WORD_BYTES);

  state_t              r_state;
  req_t                r_req;
  logic                r_fault;
  logic [WAIT_W-1:0]   r_cnt;
  logic [31:0]         r_rdata;
  logic [31:0]         r_last_adr;
  logic [31:0]         r_last_data;
  logic [15:0]         r_st_cnt;

  logic                w_acc_fault;
  logic                w_resp;
  logic                w_ram_we;
  logic [AW-1:0]       w_ram_addr;
  logic [31:0]         w_ram_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_acc_fault = (|(DataAdr >> (AW + OFS))) | (|DataAdr[OFS-1:0]);
`else
  assign w_acc_fault = |(DataAdr >> (AW + OFS));
`endif

  // In IDLE the RAM reads the live bus so a zero-wait load has data in RESP.
  assign w_ram_addr = (r_state == IDLE) ? DataAdr[AW+OFS-1:OFS] : r_req.adr[AW+OFS-1:OFS];
  assign w_resp     = (r_state == RESP);
  assign w_ram_we   = w_resp & r_req.we & ~r_fault;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_last_adr  <= '0;
      r_last_data <= '0;
      r_st_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MemReq) begin
            r_req.we    <= MemWrite;
            r_req.adr   <= DataAdr;
            r_req.wdata <= WriteData;
            r_fault     <= w_acc_fault;
            r_cnt       <= WAIT_W'(WAIT_STATES);
            r_state     <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= WAIT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (!r_req.we) begin
            r_rdata <= r_fault ? 32'd0 : w_ram_q;
          end else if (!r_fault) begin
            r_last_adr  <= r_req.adr;
            r_last_data <= r_req.wdata;
            r_st_cnt    <= r_st_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ReadData = r_rdata;
    if (w_resp && r_fault) begin
      ReadData = 32'd0;
    end else if (w_resp && !r_req.we) begin
      ReadData = w_ram_q;
    end
  end

  assign MemReady   = w_resp;
  assign MemErr     = w_resp & r_fault;
  assign LastStAdr  = r_last_adr;
  assign LastStData = r_last_data;
  assign StCount    = r_st_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=2 and 0), table-driven accesses with a response scoreboard.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic [31:0] last_adr  [2];
  logic [31:0] last_data [2];
  logic [15:0] stc   [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .MemReq(req[0]), .MemWrite(we[0]), .DataAdr(adr[0]),
    .WriteData(wdat[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .MemErr(err[0]),
    .LastStAdr(last_adr[0]), .LastStData(last_data[0]), .StCount(stc[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .MemReq(req[1]), .MemWrite(we[1]), .DataAdr(adr[1]),
    .WriteData(wdat[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .MemErr(err[1]),
    .LastStAdr(last_adr[1]), .LastStData(last_data[1]), .StCount(stc[1])
  );

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    bit          hold;
  } vec_t;

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          acc;
  } exp_t;

  vec_t        tbl [16];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] m_adr  [2];
  logic [31:0] m_data [2];
  logic [15:0] m_cnt  [2];

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Response monitor: every MemReady must match the oldest accepted access.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready dut%0d actual=1 required=0", d);
        end else begin
          e = sb.pop_front();
          chk("resp_dut", 32'(d), 32'(e.d));
          chk("mem_err", 32'(err[d]), 32'(e.err));
          chk("latency", 32'(cyc - e.acc + 1), (d == 0) ? 32'd3 : 32'd1);
          if (!e.we) chk("read_data", rdata[d], e.rd);
          if (e.we && !e.err) begin
            m_adr[d]  = e.adr;
            m_data[d] = e.wd;
            m_cnt[d]  = m_cnt[d] + 16'd1;
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic start_acc(int d, logic w, logic [31:0] a, logic [31:0] wd, logic e, logic [31:0] rd);
    exp_t x;
    we[d]   = w;
    adr[d]  = a;
    wdat[d] = wd;
    req[d]  = 1'b1;
    @(posedge clk);
    #1;
    x.d = d; x.we = w; x.adr = a; x.wd = wd; x.err = e; x.rd = rd; x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic finish_acc(int d, bit hold);
    int n;
    bit ok;
    if (!hold) req[d] = 1'b0;
    n  = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (done_cnt != n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d actual=none required=ready", d);
    end
    chk("last_st_adr", last_adr[d], m_adr[d]);
    chk("last_st_data", last_data[d], m_data[d]);
    chk("st_count", 32'(stc[d]), 32'(m_cnt[d]));
  endtask

  task automatic chk_zero(int d, string tag);
    chk({tag, "_ready"}, 32'(rdy[d]), 32'd0);
    chk({tag, "_err"}, 32'(err[d]), 32'd0);
    chk({tag, "_rdata"}, rdata[d], 32'd0);
    chk({tag, "_last_adr"}, last_adr[d], 32'd0);
    chk({tag, "_last_data"}, last_data[d], 32'd0);
    chk({tag, "_st_count"}, 32'(stc[d]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; wdat[d] = '0;
      m_adr[d] = '0; m_data[d] = '0; m_cnt[d] = '0;
    end

    tbl[0]  = '{0, 1'b1, 32'h14,  32'h2,        1'b0, 32'h0,        1'b0};
    tbl[1]  = '{0, 1'b0, 32'h14,  32'h0,        1'b0, 32'h2,        1'b0};
    tbl[2]  = '{0, 1'b1, 32'h4,   32'h55,       1'b0, 32'h0,        1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[3]  = '{0, 1'b1, 32'h6,   32'h11,       1'b1, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b0, 32'h4,   32'h0,        1'b0, 32'h55,       1'b0};
`else
    tbl[3]  = '{0, 1'b1, 32'h6,   32'h11,       1'b0, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b0, 32'h4,   32'h0,        1'b0, 32'h11,       1'b0};
`endif
    tbl[5]  = '{0, 1'b1, 32'h10,  32'h44,       1'b0, 32'h0,        1'b0};
    tbl[6]  = '{0, 1'b1, 32'h8,   32'h33,       1'b0, 32'h0,        1'b0};
    tbl[7]  = '{0, 1'b1, 32'hFC,  32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{0, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        1'b0};
    tbl[10] = '{1, 1'b1, 32'h0,   32'hA5A5A5A5, 1'b0, 32'h0,        1'b1};
    tbl[11] = '{1, 1'b1, 32'h4,   32'h5A5A5A5A, 1'b0, 32'h0,        1'b1};
    tbl[12] = '{1, 1'b0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5, 1'b1};
    tbl[13] = '{1, 1'b0, 32'h4,   32'h0,        1'b0, 32'h5A5A5A5A, 1'b1};
    tbl[14] = '{1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1};
    tbl[15] = '{1, 1'b0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      start_acc(tbl[i].d, tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].err, tbl[i].rd);
      finish_acc(tbl[i].d, tbl[i].hold);
    end

    // Bus changes after acceptance must not affect the committed store.
    start_acc(0, 1'b1, 32'hC, 32'h1, 1'b0, 32'h0);
    adr[0]  = 32'h10;
    wdat[0] = 32'h2;
    finish_acc(0, 1'b0);
    chk("chg_last_adr", last_adr[0], 32'hC);
    start_acc(0, 1'b0, 32'hC, 32'h0, 1'b0, 32'h1);
    finish_acc(0, 1'b0);
    start_acc(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h44);
    finish_acc(0, 1'b0);

    // Reset during WAIT of a store: access abandoned, outputs clear at once.
    we[0] = 1'b1; adr[0] = 32'h8; wdat[0] = 32'h77; req[0] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '0; m_data[d] = '0; m_cnt[d] = '0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_acc(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h33);
    finish_acc(0, 1'b0);
    chk("pending_left", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
